// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - eight-phase instruction sequencer for a simple accumulator CPU
//
// Purpose: walks each instruction through phases P0..P7, decoding memory, PC,
// IR and accumulator control strobes from the current phase, the IR opcode and
// the ALU zero flag. It also counts retired instructions.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   run                 start/resume request, honoured only in STOP or HALTED
//   opcode[2:0], zero   IR opcode field and accumulator-is-zero flag
//   sel, rd, ld_ir      address select (1 = PC), memory read, IR load
//   inc_pc, ld_pc       PC increment, PC load from IR address
//   ld_ac, wr, data_e   accumulator load, memory write, accumulator bus drive
//   halt, busy          halted indication, instruction cycle in progress
//   phase[2:0]          current phase index (0 when not busy)
//   instr_cnt[7:0]      retired-instruction count, wraps at 256
//
// Build option: define CPU_SEQUENCER_STEP_EN to return to STOP after every P7
// (single-step mode); by default execution is continuous until HLT.

module cpu_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic       busy,
    output logic [2:0] phase,
    output logic [7:0] instr_cnt
);

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [3:0] {
        S_STOP   = 4'd0,
        S_P0     = 4'd1,
        S_P1     = 4'd2,
        S_P2     = 4'd3,
        S_P3     = 4'd4,
        S_P4     = 4'd5,
        S_P5     = 4'd6,
        S_P6     = 4'd7,
        S_P7     = 4'd8,
        S_HALTED = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       alu_op;
    logic       is_hlt;

    assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);
    assign is_hlt = (opcode == OP_HLT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_STOP;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel     = 1'b0;
        rd      = 1'b0;
        ld_ir   = 1'b0;
        inc_pc  = 1'b0;
        ld_pc   = 1'b0;
        ld_ac   = 1'b0;
        wr      = 1'b0;
        data_e  = 1'b0;
        halt    = 1'b0;
        busy    = 1'b1;
        phase   = 3'd0;

        case (state_q)
            S_STOP: begin
                busy = 1'b0;
                if (run) state_d = S_P0;
            end
            S_P0: begin
                phase   = 3'd0;
                sel     = 1'b1;
                state_d = S_P1;
            end
            S_P1: begin
                phase   = 3'd1;
                sel     = 1'b1;
                rd      = 1'b1;
                state_d = S_P2;
            end
            S_P2: begin
                phase   = 3'd2;
                sel     = 1'b1;
                rd      = 1'b1;
                ld_ir   = 1'b1;
                state_d = S_P3;
            end
            S_P3: begin
                phase   = 3'd3;
                sel     = 1'b1;
                rd      = 1'b1;
                ld_ir   = 1'b1;
                state_d = S_P4;
            end
            S_P4: begin
                phase  = 3'd4;
                inc_pc = 1'b1;
                halt   = is_hlt;
                // A halting instruction retires here since it never reaches P7.
                if (is_hlt) begin
                    state_d = S_HALTED;
                    cnt_d   = cnt_q + 8'd1;
                end else begin
                    state_d = S_P5;
                end
            end
            S_P5: begin
                phase   = 3'd5;
                rd      = alu_op;
                state_d = S_P6;
            end
            S_P6: begin
                phase   = 3'd6;
                rd      = alu_op;
                // zero is looked at only here: the second increment skips the next word.
                inc_pc  = (opcode == OP_SKZ) && zero;
                ld_pc   = (opcode == OP_JMP);
                data_e  = (opcode == OP_STO);
                state_d = S_P7;
            end
            S_P7: begin
                phase  = 3'd7;
                rd     = alu_op;
                ld_ac  = alu_op;
                ld_pc  = (opcode == OP_JMP);
                wr     = (opcode == OP_STO);
                data_e = (opcode == OP_STO);
                cnt_d  = cnt_q + 8'd1;
`ifdef CPU_SEQUENCER_STEP_EN
                state_d = S_STOP;
`else
                state_d = S_P0;
`endif
            end
            S_HALTED: begin
                busy = 1'b0;
                halt = 1'b1;
                if (run) state_d = S_P0;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_STOP;
            end
        endcase
    end

    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer

module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, run, zero;
    logic [2:0] opcode;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, busy;
    logic [2:0] phase;
    logic [7:0] instr_cnt;
    logic [8:0] obs;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_cnt;

    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, STO = 3'd6, JMP = 3'd7;

    // Strobe order: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
    localparam logic [8:0] Z    = 9'b000000000;
    localparam logic [8:0] F0   = 9'b100000000;
    localparam logic [8:0] F1   = 9'b110000000;
    localparam logic [8:0] F2   = 9'b111000000;
    localparam logic [8:0] INC  = 9'b000100000;
    localparam logic [8:0] RD   = 9'b010000000;
    localparam logic [8:0] RDAC = 9'b010001000;
    localparam logic [8:0] LPC  = 9'b000010000;
    localparam logic [8:0] DE   = 9'b000000010;
    localparam logic [8:0] WRDE = 9'b000000110;
    localparam logic [8:0] HLT4 = 9'b000100001;
    localparam logic [8:0] HOLD = 9'b000000001;

    localparam logic [71:0] V_ADD  = {F0, F1, F2, F2, INC, RD, RD, RDAC};
    localparam logic [71:0] V_SKZ1 = {F0, F1, F2, F2, INC, Z, INC, Z};
    localparam logic [71:0] V_SKZ0 = {F0, F1, F2, F2, INC, Z, Z, Z};
    localparam logic [71:0] V_JMP  = {F0, F1, F2, F2, INC, Z, LPC, LPC};
    localparam logic [71:0] V_STO  = {F0, F1, F2, F2, INC, Z, DE, WRDE};
    localparam logic [71:0] V_HLT  = {F0, F1, F2, F2, HLT4, Z, Z, Z};

    cpu_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .opcode    (opcode),
        .zero      (zero),
        .sel       (sel),
        .rd        (rd),
        .ld_ir     (ld_ir),
        .inc_pc    (inc_pc),
        .ld_pc     (ld_pc),
        .ld_ac     (ld_ac),
        .wr        (wr),
        .data_e    (data_e),
        .halt      (halt),
        .busy      (busy),
        .phase     (phase),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

    task automatic chk(input string tag, input int idx, input logic [8:0] o, input logic [8:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, o, e);
        end
    endtask

    // Pulse run for one clock; caller sits at a negedge in STOP or HALTED and
    // returns at the negedge where the FSM is in P0.
    task automatic go();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    // Entered at a negedge in P0; checks n phases and advances past each.
    task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                             input logic [71:0] ev, input int n);
        opcode = op;
        zero   = z;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_strobes"}, i, obs, ev[(7-i)*9 +: 9]);
            chk({tag, "_busy"}, i, {8'd0, busy}, 9'd1);
            chk({tag, "_phase"}, i, {6'd0, phase}, 9'(i));
            if (i == 7) zero = ~z;
            @(negedge clk);
        end
    endtask

    // After a full instruction: continuous build is already in P0, step build
    // must sit idle in STOP until run is pulsed again.
    task automatic next_instr(input string tag);
`ifdef CPU_SEQUENCER_STEP_EN
        chk({tag, "_step_idle"}, 0, {8'd0, busy}, 9'd0);
        @(negedge clk);
        chk({tag, "_step_idle"}, 1, {8'd0, busy}, 9'd0);
        go();
`else
        chk({tag, "_cont_p0"}, 0, {6'd0, phase}, 9'd0);
`endif
    endtask

    initial begin
        rst_n  = 1'b0;
        run    = 1'b0;
        zero   = 1'b0;
        opcode = ADD;
        exp_cnt = 8'd0;

        @(negedge clk);
        chk("reset_strobes", 0, obs, Z);
        chk("reset_busy", 0, {8'd0, busy}, 9'd0);
        chk("reset_cnt", 0, {1'b0, instr_cnt}, 9'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_stop", 0, {5'd0, busy, phase}, 9'd0);

        go();
        run_instr("add", ADD, 1'b0, V_ADD, 8);
        exp_cnt = 8'd1;
        chk("add_cnt", 0, {1'b0, instr_cnt}, {1'b0, exp_cnt});
        next_instr("add");

        run_instr("skz1", SKZ, 1'b1, V_SKZ1, 8);
        exp_cnt = 8'd2;
        chk("skz1_cnt", 0, {1'b0, instr_cnt}, {1'b0, exp_cnt});
        next_instr("skz1");

        run_instr("skz0", SKZ, 1'b0, V_SKZ0, 8);
        next_instr("skz0");

        run_instr("jmp", JMP, 1'b0, V_JMP, 8);
        next_instr("jmp");

        run_instr("sto", STO, 1'b0, V_STO, 8);
        exp_cnt = 8'd5;
        chk("sto_cnt", 0, {1'b0, instr_cnt}, {1'b0, exp_cnt});
        next_instr("sto");

        run_instr("hlt", HLT, 1'b0, V_HLT, 5);
        for (int i = 0; i < 10; i++) begin
            chk("halted_strobes", i, obs, HOLD);
            chk("halted_busy", i, {5'd0, busy, phase}, 9'd0);
            chk("halted_cnt", i, {1'b0, instr_cnt}, 9'd6);
            @(negedge clk);
        end
        go();
        chk("resume_halt", 0, {7'd0, halt, busy}, 9'd1);

        run_instr("sto_rst", STO, 1'b0, V_STO, 7);
        chk("sto_rst_p7", 0, obs, WRDE);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_strobes", 0, obs, Z);
        chk("rst_mid_busy", 0, {8'd0, busy}, 9'd0);
        chk("rst_mid_cnt", 0, {1'b0, instr_cnt}, 9'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_stop", 0, {8'd0, busy}, 9'd0);

        opcode = ADD;
        go();
        for (int k = 1; k <= 256; k++) begin
            repeat (8) @(negedge clk);
            if (k == 255) chk("wrap_255", 0, {1'b0, instr_cnt}, 9'd255);
            if (k == 256) chk("wrap_0", 0, {1'b0, instr_cnt}, 9'd0);
`ifdef CPU_SEQUENCER_STEP_EN
            if (k == 1) chk("step_stop", 0, {8'd0, busy}, 9'd0);
            go();
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have the following ports (name direction width meaning), with clock and reset first:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  level request to start or resume execution.
- opcode  in  3  instruction register opcode field; stable from phase P3 onward.
- zero  in  1  accumulator-is-zero flag from the ALU.
- sel  out  1  memory address mux select (1 = PC address, 0 = IR operand address).
- rd  out  1  memory read enable.
- ld_ir  out  1  instruction register load.
- inc_pc  out  1  program counter increment.
- ld_pc  out  1  program counter load from IR address.
- ld_ac  out  1  accumulator load.
- wr  out  1  memory write enable.
- data_e  out  1  accumulator-to-data-bus drive enable.
- halt  out  1  halted indication.
- busy  out  1  an instruction cycle is in progress.
- phase  out  3  current phase index, 0..7 (0 when not busy).
- instr_cnt  out  8  count of retired instructions.

REQ-002 Opcode encoding SHALL be HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
REQ-003 ALUOP SHALL mean opcode is one of ADD, AND, XOR or LDA.

Function
REQ-004 The FSM SHALL have states STOP, P0..P7 and HALTED, held in a state register.
REQ-005 STOP SHALL go to P0 when run=1; otherwise it SHALL stay in STOP.
REQ-006 Pn SHALL advance to Pn+1 unconditionally, except at P4 and P7 (REQ-007, REQ-008).
REQ-007 P4 SHALL go to HALTED if opcode=HLT; otherwise it SHALL go to P5.
REQ-008 P7 SHALL go to P0 (see REQ-020 for the build-time alternative).
REQ-009 HALTED SHALL go to P0 when run=1; otherwise it SHALL stay in HALTED.
REQ-010 Outputs SHALL be combinational decodes of the state register, opcode and zero; every output not listed for a state SHALL be 0:
- P0: sel.
- P1: sel, rd.
- P2 and P3: sel, rd, ld_ir.
- P4: inc_pc; halt if opcode=HLT.
- P5: rd if ALUOP.
- P6: rd if ALUOP; inc_pc if (SKZ and zero); ld_pc if JMP; data_e if STO.
- P7: rd and ld_ac if ALUOP; ld_pc if JMP; wr and data_e if STO.
- STOP: all outputs 0.
- HALTED: halt only.
REQ-011 busy SHALL be 1 exactly in P0..P7, and phase SHALL equal the P index in those states.
REQ-012 The instruction cycle SHALL be 8 clocks; the PC SHALL see exactly one inc_pc pulse per non-skipping instruction and two per taken SKZ.
REQ-013 instr_cnt SHALL increment by 1 on each P7 exit and on each P4-to-HALTED transition, and SHALL wrap from 255 to 0.
REQ-014 run SHALL be ignored in P0..P7; a run deassertion mid-cycle SHALL NOT abort the instruction.
REQ-015 zero SHALL be sampled only in P6; a change of zero in P7 SHALL have no effect.
REQ-016 wr and ld_pc SHALL never be asserted in the same cycle for any opcode.

Reset
REQ-017 rst_n=0 SHALL immediately, without waiting for clk, force state to STOP and instr_cnt to 0, which drives all outputs to 0.
REQ-018 A reset asserted in any phase, including P7 with wr=1, SHALL deassert every output within the same cycle, and the interrupted instruction SHALL NOT be counted.
REQ-019 After rst_n is released, the FSM SHALL remain in STOP until run=1 is sampled at a rising clk edge.

Configuration
REQ-020 With macro CPU_SEQUENCER_STEP_EN defined, P7 SHALL go to STOP instead of P0, so each run assertion executes exactly one instruction. Without the macro, P7 SHALL go to P0 and execution SHALL be continuous until HLT. All other behaviour SHALL be identical in both builds.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Reset, then run=1 for 1 clk, with opcode=ADD -> phase 0..7 in consecutive clks; rd=1 in P1,P2,P3,P5,P6,P7; ld_ac=1 only in P7; instr_cnt=1 after P7.
- opcode=SKZ with zero=1 -> inc_pc=1 in both P4 and P6. Repeat with zero=0 -> inc_pc=1 in P4 only.
- opcode=JMP -> ld_pc=1 in P6 and P7, inc_pc=1 in P4. opcode=STO -> data_e=1 in P6 and P7, wr=1 in P7 only.
- opcode=HLT -> halt=1 in P4, then state HALTED with halt=1 held for 10 clks and instr_cnt incremented once; then run=1 -> P0 next clk with halt=0.
- rst_n=0 asserted mid-clock in P7 of a STO -> wr, data_e and busy go to 0 before the next edge, and instr_cnt=0.
- 256 ADD instructions run back to back -> instr_cnt reads 255, then wraps to 0. With CPU_SEQUENCER_STEP_EN defined -> STOP after each P7, and busy=0 until the next run.
